load_store_buffer: RTL

In-order queue for memory instructions in the out-of-order core. Accepts load/store micro-ops from the decoder and captures operands from result broadcasts. Each op runs against the memory controller only when it is at the queue head. Load results and store "address ready" acknowledgements go to the reorder buffer. A store writes memory only after the reorder buffer commits it, so memory state is never speculative.

---
 rtl/load_store_buffer_pkg.sv | 43 ++++
 rtl/load_store_buffer_load_align.sv | 22 ++
 rtl/load_store_buffer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_buffer_pkg.sv
// Shared sizing, encodings and entry layout for load_store_buffer.
// Optional feature macro: LSB_IO_GUARD_EN (hold IO-space loads until they are the reorder buffer head).
`ifndef LSB_SIZE
`define LSB_SIZE 8
`endif
`ifndef LSB_WIDTH
`define LSB_WIDTH 3
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
`ifndef LSB_IO_BASE
`define LSB_IO_BASE 32'h0003_0000
`endif

package load_store_buffer_pkg;
  localparam int unsigned LSB_SIZE  = `LSB_SIZE;
  localparam int unsigned LSB_WIDTH = `LSB_WIDTH;
  localparam int unsigned ROB_WIDTH = `ROB_WIDTH;
  localparam logic [31:0] IO_BASE   = `LSB_IO_BASE;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_DRAIN} lsb_state_e;

  typedef struct packed {
    logic                 is_store;
    logic [1:0]           size;
    logic                 uns;
    logic [ROB_WIDTH-1:0] rob_id;
    logic [31:0]          imm;
    logic [31:0]          vj;
    logic [ROB_WIDTH-1:0] qj;
    logic                 rj;
    logic [31:0]          vk;
    logic [ROB_WIDTH-1:0] qk;
    logic                 rk;
    logic                 reported;
    logic                 committed;
  } lsb_entry_t;
endpackage

// File: rtl/load_store_buffer_load_align.sv
// Extracts the addressed byte/half/word from raw read data and sign- or zero-extends it.
module lsb_load_align
  import load_store_buffer_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_c_o
);
  logic [31:0] shifted;

  always_comb begin
    shifted  = rdata_i >> {addr_lo_i, 3'b000};
    data_c_o = rdata_i;
    case (size_i)
      SIZE_BYTE: data_c_o = {{24{~uns_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data_c_o = {{16{~uns_i & shifted[15]}}, shifted[15:0]};
      default:   data_c_o = rdata_i;
    endcase
  end
endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue: captures operands, issues the head op to memory, stores only after commit.
// Optional feature macro: LSB_IO_GUARD_EN.
module load_store_buffer
  import load_store_buffer_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  output logic                 dec_full,
  input  logic                 dec_en,
  input  logic [2:0]           dec_op,
  input  logic                 dec_unsigned,
  input  logic [ROB_WIDTH-1:0] dec_rob_id,
  input  logic [31:0]          dec_imm,
  input  logic                 dec_rs1_ready,
  input  logic                 dec_rs2_ready,
  input  logic [31:0]          dec_rs1_val,
  input  logic [31:0]          dec_rs2_val,
  input  logic [ROB_WIDTH-1:0] dec_rs1_tag,
  input  logic [ROB_WIDTH-1:0] dec_rs2_tag,
  input  logic                 rs_rdy,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]          rs_data,
  output logic                 rob_rdy,
  output logic [ROB_WIDTH-1:0] rob_rob_id,
  output logic [31:0]          rob_data,
  input  logic                 commit_empty,
  input  logic [ROB_WIDTH-1:0] commit_current_rob_id,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [1:0]           mem_size,
  input  logic                 mem_done,
  input  logic [31:0]          mem_rdata
);
  localparam int unsigned CW = LSB_WIDTH + 1;

  lsb_entry_t           ent_q [LSB_SIZE];
  logic [LSB_SIZE-1:0]  busy_q;
  logic [LSB_WIDTH-1:0] head_q, tail_q;
  logic [CW-1:0]        count_q;
  lsb_state_e           state_q;
  logic                 rob_rdy_q, mem_req_q, mem_we_q;
  logic [ROB_WIDTH-1:0] rob_rob_id_q;
  logic [31:0]          rob_data_q, mem_addr_q, mem_wdata_q;
  logic [1:0]           mem_size_q;

  lsb_entry_t    head_e, new_e;
  logic [31:0]   head_addr, load_data;
  logic          head_busy, eligible, store_ack, push, pop;
  logic [CW-1:0] commit_cnt;

  assign head_e    = ent_q[head_q];
  assign head_busy = busy_q[head_q];
  assign head_addr = head_e.vj + head_e.imm;
  assign dec_full  = (count_q == CW'(LSB_SIZE));
  assign push      = dec_en && !dec_full && !flush;
  assign pop       = (state_q == ST_MEM) && mem_done;
  assign store_ack = (state_q == ST_IDLE) && head_busy && head_e.is_store &&
                     head_e.rj && head_e.rk && !head_e.reported;

  assign rob_rdy    = rob_rdy_q;
  assign rob_rob_id = rob_rob_id_q;
  assign rob_data   = rob_data_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_size   = mem_size_q;

  lsb_load_align u_align (
    .rdata_i   (mem_rdata),
    .size_i    (mem_size_q),
    .uns_i     (head_e.uns),
    .addr_lo_i (mem_addr_q[1:0]),
    .data_c_o  (load_data)
  );

  // Head may start a memory access this cycle.
  always_comb begin
    eligible = 1'b0;
    if (head_busy && head_e.rj) begin
      if (head_e.is_store) eligible = head_e.rk && head_e.committed;
      else                 eligible = 1'b1;
`ifdef LSB_IO_GUARD_EN
      if (!head_e.is_store && (head_addr >= IO_BASE))
        eligible = !commit_empty && (commit_current_rob_id == head_e.rob_id);
`endif
    end
  end

  // Committed stores form a contiguous head prefix, so their count sets the post-flush tail.
  always_comb begin
    commit_cnt = '0;
    for (int unsigned i = 0; i < LSB_SIZE; i++)
      if (busy_q[LSB_WIDTH'(i)] && ent_q[LSB_WIDTH'(i)].committed) commit_cnt = commit_cnt + CW'(1);
  end

  // New entry, capturing any same-cycle broadcast for a not-ready source.
  always_comb begin
    new_e          = '0;
    new_e.is_store = dec_op[2];
    new_e.size     = dec_op[1:0];
    new_e.uns      = dec_unsigned;
    new_e.rob_id   = dec_rob_id;
    new_e.imm      = dec_imm;
    new_e.vj       = dec_rs1_val;
    new_e.qj       = dec_rs1_tag;
    new_e.rj       = dec_rs1_ready;
    new_e.vk       = dec_rs2_val;
    new_e.qk       = dec_rs2_tag;
    new_e.rk       = dec_rs2_ready;
    if (!dec_rs1_ready && rs_rdy && (dec_rs1_tag == rs_rob_id)) begin
      new_e.vj = rs_data;    new_e.rj = 1'b1;
    end else if (!dec_rs1_ready && rob_rdy_q && (dec_rs1_tag == rob_rob_id_q)) begin
      new_e.vj = rob_data_q; new_e.rj = 1'b1;
    end
    if (!dec_rs2_ready && rs_rdy && (dec_rs2_tag == rs_rob_id)) begin
      new_e.vk = rs_data;    new_e.rk = 1'b1;
    end else if (!dec_rs2_ready && rob_rdy_q && (dec_rs2_tag == rob_rob_id_q)) begin
      new_e.vk = rob_data_q; new_e.rk = 1'b1;
    end
  end

  // Queue storage, wakeup, commit marking and pointer bookkeeping.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < LSB_SIZE; i++) ent_q[LSB_WIDTH'(i)] <= '0;
    end else if (rdy_in) begin
      for (int unsigned i = 0; i < LSB_SIZE; i++) begin
        if (busy_q[LSB_WIDTH'(i)]) begin
          if (!ent_q[LSB_WIDTH'(i)].rj && rs_rdy && (ent_q[LSB_WIDTH'(i)].qj == rs_rob_id)) begin
            ent_q[LSB_WIDTH'(i)].vj <= rs_data;    ent_q[LSB_WIDTH'(i)].rj <= 1'b1;
          end else if (!ent_q[LSB_WIDTH'(i)].rj && rob_rdy_q && (ent_q[LSB_WIDTH'(i)].qj == rob_rob_id_q)) begin
            ent_q[LSB_WIDTH'(i)].vj <= rob_data_q; ent_q[LSB_WIDTH'(i)].rj <= 1'b1;
          end
          if (!ent_q[LSB_WIDTH'(i)].rk && rs_rdy && (ent_q[LSB_WIDTH'(i)].qk == rs_rob_id)) begin
            ent_q[LSB_WIDTH'(i)].vk <= rs_data;    ent_q[LSB_WIDTH'(i)].rk <= 1'b1;
          end else if (!ent_q[LSB_WIDTH'(i)].rk && rob_rdy_q && (ent_q[LSB_WIDTH'(i)].qk == rob_rob_id_q)) begin
            ent_q[LSB_WIDTH'(i)].vk <= rob_data_q; ent_q[LSB_WIDTH'(i)].rk <= 1'b1;
          end
          if (ent_q[LSB_WIDTH'(i)].is_store && !commit_empty &&
              (commit_current_rob_id == ent_q[LSB_WIDTH'(i)].rob_id))
            ent_q[LSB_WIDTH'(i)].committed <= 1'b1;
        end
      end
      if (store_ack && !flush) ent_q[head_q].reported <= 1'b1;

      if (flush) begin
        for (int unsigned i = 0; i < LSB_SIZE; i++)
          if (!ent_q[LSB_WIDTH'(i)].committed) busy_q[LSB_WIDTH'(i)] <= 1'b0;
        tail_q <= head_q + LSB_WIDTH'(commit_cnt);
        if (pop && head_e.committed) begin
          busy_q[head_q] <= 1'b0;
          head_q         <= head_q + LSB_WIDTH'(1);
          count_q        <= commit_cnt - CW'(1);
        end else begin
          count_q <= commit_cnt;
        end
      end else begin
        if (push) begin
          ent_q[tail_q]  <= new_e;
          busy_q[tail_q] <= 1'b1;
          tail_q         <= tail_q + LSB_WIDTH'(1);
        end
        if (pop) begin
          busy_q[head_q] <= 1'b0;
          head_q         <= head_q + LSB_WIDTH'(1);
        end
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  // Memory/ROB handshake FSM with registered outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= ST_IDLE;
      rob_rdy_q    <= 1'b0;
      rob_rob_id_q <= '0;
      rob_data_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_size_q   <= '0;
    end else if (rdy_in) begin
      rob_rdy_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (eligible && !flush) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= head_e.is_store;
            mem_addr_q  <= head_addr;
            mem_wdata_q <= head_e.vk;
            mem_size_q  <= head_e.size;
            state_q     <= ST_MEM;
          end else if (store_ack && !flush) begin
            rob_rdy_q    <= 1'b1;
            rob_rob_id_q <= head_e.rob_id;
            rob_data_q   <= '0;
          end
        end
        ST_MEM: begin
          if (mem_done) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= ST_IDLE;
            if (!head_e.is_store && !flush) begin
              rob_rdy_q    <= 1'b1;
              rob_rob_id_q <= head_e.rob_id;
              rob_data_q   <= load_data;
            end
          end else if (flush && !head_e.is_store) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (mem_done) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule
